i2c_reg_target: RTL and testbench
=================================

I2C_REG_TARGET -- requirements
Module: i2c_reg_target

Interface
REQ-001 The block SHALL have parameter TARGET_ADDR, default 7'h20: 7-bit I2C address matched by the block.
REQ-002 The block SHALL have parameter REG_COUNT, default 32: number of 8-bit registers, legal range 2..256.
REQ-003 The block SHALL have parameter RO_COUNT, default 1: registers 0..RO_COUNT-1 are read-only and loaded from parallel_in; legal range 0..REG_COUNT-1.
REQ-004 The block SHALL have parameter FILTER_LEN, default 3: number of consecutive equal samples required to accept a new SCL/SDA level.
REQ-005 The block SHALL have derived constant PW = max(1, clog2(REG_COUNT)).
REQ-006 The block SHALL have port clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have ports scl_in and sda_in, input, 1 bit each: raw, asynchronous bus levels.
REQ-009 The block SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low, 0 releases it.
REQ-010 The block SHALL have port parallel_in, input, 8*max(RO_COUNT,1) bits: byte j feeds read-only register j.
REQ-011 The block SHALL have port registers_packed, output, 8*REG_COUNT bits: register j occupies bits [8j+7:8j].
REQ-012 The block SHALL have ports wr_strobe (1 bit) and wr_index (PW bits), output: one-cycle pulse plus the index of each committed write.
REQ-013 The block SHALL have port busy, output, 1 bit: high from an address match until STOP or return to IDLE.

Function
REQ-014 Each of scl_in and sda_in SHALL pass through a 2-flop synchronizer and then a FILTER_LEN glitch filter; rise/fall pulses SHALL be one clock wide. The clock frequency SHALL be at least 16x SCL.
REQ-015 A SDA fall while filtered SCL=1 SHALL be detected as START, and a SDA rise while SCL=1 as STOP; both SHALL be honoured in every state, with START going to ADDR (repeated start) and STOP going to IDLE.
REQ-016 FSM states SHALL be IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WRITE_ACK, READ, READ_ACK and IGNORE.
REQ-017 Bits SHALL be sampled on the SCL rise, MSB first; a 3-bit bit counter SHALL advance on each SCL rise and clear on START and in each ACK state.
REQ-018 ADDR: after 8 bits, if addr[7:1]==TARGET_ADDR, go to ADDR_ACK; otherwise go to IGNORE. IGNORE is left only on START or STOP.
REQ-019 ADDR_ACK SHALL drive sda_oe=1 from the SCL fall after bit 8 until the next SCL fall; then R/W=0 goes to PTR, and R/W=1 goes to READ.
REQ-020 PTR: a received byte < REG_COUNT SHALL load the pointer and ACK, then go to WRITE. A byte >= REG_COUNT SHALL be NACKed (sda_oe=0), leave the pointer unchanged, and go to IGNORE.
REQ-021 WRITE: each byte SHALL be ACKed. If pointer >= RO_COUNT, the register is written and wr_strobe/wr_index pulse at the SCL fall ending the ACK. Writes to read-only indices SHALL be ACKed, discarded and not strobed. The pointer SHALL then increment.
REQ-022 READ: at entry, and after each master ACK, register[pointer] SHALL be snapshotted into a shift register; sda_oe = ~bit, updated within 2 clocks after each SCL fall.
REQ-023 READ_ACK: sda_oe=0. Master ACK (SDA=0 at SCL rise) increments the pointer and returns to READ. NACK goes to IGNORE.
REQ-024 Pointer increment SHALL wrap from REG_COUNT-1 to 0.
REQ-025 Read-only registers SHALL reload from double-registered parallel_in every clock; a snapshot taken by REQ-022 SHALL not tear.
REQ-026 The pointer SHALL persist across transactions; a read with no pointer phase starts at the last pointer.
REQ-027 sda_oe SHALL be 0 in IDLE, ADDR, PTR, WRITE and IGNORE, except during the ACK windows of REQ-019 to REQ-021.

Reset
REQ-028 While reset=0, the block SHALL hold: state=IDLE, sda_oe=0, busy=0, wr_strobe=0, wr_index=0, pointer=0, all writable registers=8'h00, synchronizer/filter flops=1 (bus idle).
REQ-029 Reset asserted mid-transaction SHALL release SDA within that cycle; after release, the block SHALL ignore the bus until the next START.

Structure
REQ-030 Package i2c_pkg SHALL hold the FSM state enum, the ACK/NACK level constants and the minimum clock-to-SCL ratio constant.
REQ-031 Sub-module i2c_bus_filter (synchronizer + glitch filter + edge pulses) SHALL be instantiated once for SCL and once for SDA.

Verification
REQ-032 Write 0x40,0x05,0xA5,0x3C then STOP -> reg5=A5, reg6=3C, two wr_strobe pulses (wr_index 5 then 6), all bytes ACKed.
REQ-033 parallel_in=0x77, write 0x40,0x00 then repeated START, 0x41, read 2 bytes with ACK then NACK -> data 77 then reg1, pointer ends at 2.
REQ-034 Address 0x42 (target 0x21) -> address NACKed, sda_oe stays 0 and busy=0 through STOP.
REQ-035 REG_COUNT=32: write pointer 0x1F, then 3 data bytes -> reg31 and reg0..1 targeted, reg0 write discarded (RO_COUNT=1), wrap observed; pointer 0x20 -> NACK.
REQ-036 Inject 1-clock glitches on SCL during a byte -> no extra bits counted and data is unchanged.
REQ-037 Assert reset during READ with sda_oe=1 -> sda_oe=0 in that cycle, registers cleared, next transaction works.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state, bus level constants and timing ratio for the I2C register target
package i2c_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WRITE, S_WRITE_ACK, S_READ, S_READ_ACK, S_IGNORE
  } state_t;
  localparam logic ACK_LVL = 1'b0;
  localparam logic NACK_LVL = 1'b1;
  localparam int MIN_CLK_PER_SCL = 16;
endpackage

// File: rtl/i2c_bus_filter.sv
// i2c_bus_filter: 2-flop synchronizer, FILTER_LEN-sample glitch filter and one-clock edge pulses
module i2c_bus_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [1:0] r_sync;
  logic [FILTER_LEN-1:0] r_hist;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync  <= '1;
      r_hist  <= '1;
      o_level <= 1'b1;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_hist  <= FILTER_LEN'({r_hist, r_sync[1]});
      o_rise  <= &r_hist & ~o_level;
      o_fall  <= ~|r_hist & o_level;
      o_level <= &r_hist ? 1'b1 : ~|r_hist ? 1'b0 : o_level;
    end
  end
endmodule

// File: rtl/i2c_reg_target.sv
// i2c_reg_target: I2C target exposing a bank of 8-bit registers with auto-incrementing pointer
module i2c_reg_target import i2c_pkg::*; #(
  parameter logic [6:0] TARGET_ADDR = 7'h20,
  parameter int REG_COUNT = 32,
  parameter int RO_COUNT = 1,
  parameter int FILTER_LEN = 3,
  localparam int PW = ($clog2(REG_COUNT) > 1) ? $clog2(REG_COUNT) : 1,
  localparam int PIW = 8 * ((RO_COUNT > 0) ? RO_COUNT : 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   scl_in,
  input  logic                   sda_in,
  output logic                   sda_oe,
  input  logic [PIW-1:0]         parallel_in,
  output logic [8*REG_COUNT-1:0] registers_packed,
  output logic                   wr_strobe,
  output logic [PW-1:0]          wr_index,
  output logic                   busy
);
  state_t r_state;
  logic [2:0] r_bits;
  logic [7:0] r_shift, r_tx;
  logic r_phase, r_rw;
  logic [PW-1:0] r_ptr;
  logic [7:0] r_regs [REG_COUNT];
  logic [PIW-1:0] r_pin1, r_pin2;
  logic w_scl, w_scl_rise, w_scl_fall, w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic [7:0] w_byte;
  i2c_bus_filter #(.FILTER_LEN(FILTER_LEN)) u_scl (
    .clock(clock), .reset(reset), .i_raw(scl_in),
    .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );
  i2c_bus_filter #(.FILTER_LEN(FILTER_LEN)) u_sda (
    .clock(clock), .reset(reset), .i_raw(sda_in),
    .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );
  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;
  assign w_byte  = {r_shift[6:0], w_sda};
  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(REG_COUNT - 1)) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    registers_packed = '0;
    for (int j = 0; j < REG_COUNT; j++) registers_packed[8*j +: 8] = r_regs[j];
  end
  // ACK states use r_phase: first SCL fall starts driving, second fall ends the window
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_bits    <= '0;
      r_shift   <= '0;
      r_tx      <= '0;
      r_phase   <= 1'b0;
      r_rw      <= 1'b0;
      r_ptr     <= '0;
      r_pin1    <= '0;
      r_pin2    <= '0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
      for (int j = 0; j < REG_COUNT; j++) r_regs[j] <= 8'h00;
    end else begin
      r_pin1    <= parallel_in;
      r_pin2    <= r_pin1;
      for (int j = 0; j < RO_COUNT; j++) r_regs[j] <= r_pin2[8*j +: 8];
      wr_strobe <= 1'b0;
      if (w_start) begin
        r_state <= S_ADDR;
        r_bits  <= '0;
        sda_oe  <= 1'b0;
      end else if (w_stop) begin
        r_state <= S_IDLE;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_PTR, S_WRITE: if (w_scl_rise) begin
            r_shift <= w_byte;
            r_bits  <= r_bits + 3'd1;
            r_phase <= 1'b0;
            if (r_bits == 3'd7) begin
              if (r_state == S_ADDR) begin
                r_state <= (w_byte[7:1] == TARGET_ADDR) ? S_ADDR_ACK : S_IGNORE;
                busy    <= busy | (w_byte[7:1] == TARGET_ADDR);
                r_rw    <= w_byte[0];
              end else r_state <= (r_state == S_PTR) ? S_PTR_ACK : S_WRITE_ACK;
            end
          end
          S_ADDR_ACK, S_PTR_ACK, S_WRITE_ACK: begin
            r_bits <= '0;
            if (w_scl_fall && !r_phase) begin
              r_phase <= 1'b1;
              if (r_state == S_PTR_ACK && 32'(r_shift) >= REG_COUNT) begin
                sda_oe  <= ~NACK_LVL;
                r_state <= S_IGNORE;
              end else begin
                sda_oe <= ~ACK_LVL;
                if (r_state == S_PTR_ACK) r_ptr <= r_shift[PW-1:0];
              end
            end else if (w_scl_fall) begin
              sda_oe <= 1'b0;
              if (r_state == S_ADDR_ACK && r_rw) begin
                r_state <= S_READ;
                r_tx    <= r_regs[r_ptr];
                sda_oe  <= ~r_regs[r_ptr][7];
              end else if (r_state == S_ADDR_ACK) r_state <= S_PTR;
              else r_state <= S_WRITE;
              if (r_state == S_WRITE_ACK) begin
                r_ptr <= f_next(r_ptr);
                if (32'(r_ptr) >= RO_COUNT) begin
                  r_regs[r_ptr] <= r_shift;
                  wr_strobe     <= 1'b1;
                  wr_index      <= r_ptr;
                end
              end
            end
          end
          S_READ: begin
            if (w_scl_rise) r_bits <= r_bits + 3'd1;
            if (w_scl_fall && r_bits == 3'd0) begin
              r_state <= S_READ_ACK;
              sda_oe  <= 1'b0;
            end else if (w_scl_fall) begin
              r_tx   <= {r_tx[6:0], 1'b0};
              sda_oe <= ~r_tx[6];
            end
          end
          S_READ_ACK: begin
            r_bits <= '0;
            if (w_scl_rise) begin
              r_ptr <= f_next(r_ptr);
              if (w_sda != ACK_LVL) r_state <= S_IGNORE;
            end
            if (w_scl_fall) begin
              r_state <= S_READ;
              r_tx    <= r_regs[r_ptr];
              sda_oe  <= ~r_regs[r_ptr][7];
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_reg_target.sv
// tb_i2c_reg_target: directed + randomized I2C master driving the register target against a register-bank model
module tb_i2c_reg_target;
  localparam int Q = 8;
  logic clock = 1'b0, reset = 1'b0, m_scl = 1'b1, m_sda = 1'b1;
  logic [7:0] pin = 8'h77;
  logic sda_oe, wr_strobe, busy, sda_bus;
  logic [255:0] regs_p;
  logic [4:0] wr_index;
  int checks = 0, failures = 0, oe_cnt = 0, busy_cnt = 0, sbase = 0;
  int strobe_idx[$];
  int exp_strobes[$];
  logic [7:0] mregs [32];
  int mptr = 0;
  logic [7:0] wq[$];
  assign sda_bus = m_sda & ~sda_oe;
  always #5 clock = ~clock;
  i2c_reg_target dut (
    .clock(clock), .reset(reset), .scl_in(m_scl), .sda_in(sda_bus), .sda_oe(sda_oe),
    .parallel_in(pin), .registers_packed(regs_p), .wr_strobe(wr_strobe),
    .wr_index(wr_index), .busy(busy)
  );
  always @(posedge clock) begin
    if (wr_strobe) strobe_idx.push_back(int'(wr_index));
    if (sda_oe) oe_cnt++;
    if (busy) busy_cnt++;
  end
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic bit_io(input logic b, input logic g, output logic r);
    m_sda = b;
    tick(Q / 2);
    if (g) begin m_scl = 1'b1; tick(1); m_scl = 1'b0; end
    tick(Q / 2);
    m_scl = 1'b1;
    tick(Q / 2);
    if (g) begin m_scl = 1'b0; tick(1); m_scl = 1'b1; end
    tick(Q / 2);
    r = sda_bus;
    tick(Q);
    m_scl = 1'b0;
    tick(Q);
  endtask
  task automatic bus_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask
  task automatic bus_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(2 * Q);
  endtask
  task automatic send_byte(input logic [7:0] b, input logic g, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_io(b[i], g, r);
    bit_io(1'b1, 1'b0, ack);
  endtask
  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin bit_io(1'b1, 1'b0, r); d[i] = r; end
    bit_io(nack, 1'b0, r);
  endtask
  function automatic logic [7:0] mval(input int i);
    return (i == 0) ? pin : mregs[i];
  endfunction
  function automatic logic [255:0] mpacked();
    logic [255:0] v;
    for (int j = 0; j < 32; j++) v[8*j +: 8] = mval(j);
    return v;
  endfunction
  // Model: in-range pointer loads, data bytes land unless read-only, pointer wraps mod 32
  task automatic do_write(input int p, input logic g);
    logic a;
    bus_start();
    send_byte(8'h40, g, a); chk("addr_w_ack", a, 0);
    send_byte(8'(p), g, a); chk("ptr_ack", a, (p < 32) ? 0 : 1);
    foreach (wq[i]) begin send_byte(wq[i], g, a); chk("data_ack", a, (p < 32) ? 0 : 1); end
    bus_stop();
    if (p < 32) begin
      mptr = p;
      foreach (wq[i]) begin
        if (mptr >= 1) begin mregs[mptr] = wq[i]; exp_strobes.push_back(mptr); end
        mptr = (mptr + 1) % 32;
      end
    end
    chk("strobe_count", strobe_idx.size(), exp_strobes.size());
    for (int i = sbase; i < exp_strobes.size() && i < strobe_idx.size(); i++)
      chk("strobe_index", strobe_idx[i], exp_strobes[i]);
    sbase = exp_strobes.size();
    chk("regs", regs_p, mpacked());
  endtask
  task automatic do_read(input logic wp, input int p, input int n);
    logic a;
    logic [7:0] d;
    bus_start();
    if (wp) begin
      send_byte(8'h40, 1'b0, a); chk("addr_w_ack", a, 0);
      send_byte(8'(p), 1'b0, a); chk("ptr_ack", a, 0);
      mptr = p;
      bus_start();
    end
    send_byte(8'h41, 1'b0, a); chk("addr_r_ack", a, 0);
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, d);
      chk("read_data", d, mval(mptr));
      mptr = (mptr + 1) % 32;
    end
    bus_stop();
  endtask
  initial begin
    int p, n, oe0, busy0;
    logic a;
    for (int j = 0; j < 32; j++) mregs[j] = 8'h00;
    tick(4);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_wr_index", wr_index, 0);
    chk("rst_regs", regs_p, 0);
    reset = 1'b1;
    tick(2 * Q);
    wq = {8'hA5, 8'h3C};
    do_write(5, 1'b0);
    chk("reg5", regs_p[47:40], 8'hA5);
    chk("reg6", regs_p[55:48], 8'h3C);
    do_read(1'b1, 0, 2);
    do_read(1'b0, 0, 1);
    for (int it = 0; it < 4; it++) begin
      p = $urandom_range(1, 31);
      n = $urandom_range(1, 3);
      wq = {};
      for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
      do_write(p, 1'b0);
      do_read(1'b1, p, n);
    end
    oe0 = oe_cnt;
    busy0 = busy_cnt;
    bus_start();
    send_byte(8'h42, 1'b0, a); chk("wrong_addr_nack", a, 1);
    send_byte(8'h00, 1'b0, a); chk("ignored_byte_nack", a, 1);
    bus_stop();
    chk("wrong_addr_oe", oe_cnt - oe0, 0);
    chk("wrong_addr_busy", busy_cnt - busy0, 0);
    wq = {8'($urandom), 8'($urandom), 8'($urandom)};
    do_write(31, 1'b0);
    chk("reg0_ro", regs_p[7:0], 8'h77);
    wq = {8'h99};
    do_write(32, 1'b0);
    do_read(1'b0, 0, 1);
    wq = {8'($urandom)};
    do_write(7, 1'b1);
    wq = {8'h3C};
    do_write(9, 1'b0);
    bus_start();
    send_byte(8'h40, 1'b0, a);
    send_byte(8'd9, 1'b0, a);
    bus_start();
    send_byte(8'h41, 1'b0, a); chk("addr_r_ack_pre_rst", a, 0);
    tick(2);
    chk("read_drive", sda_oe, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_oe", sda_oe, 0);
    chk("rst_mid_regs", regs_p[255:8], 0);
    chk("rst_mid_busy", busy, 0);
    m_sda = 1'b1;
    m_scl = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(2 * Q);
    for (int j = 0; j < 32; j++) mregs[j] = 8'h00;
    mptr = 0;
    wq = {8'h5A};
    do_write(3, 1'b0);
    do_read(1'b1, 3, 1);
    do_read(1'b0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
